// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add sequencer that drives an external 8-bit ALU
// to form an unsigned 8x8 -> 16-bit product, one operation at a time.
module alu_mul_seq #(
    parameter logic [3:0]  OP_PASS   = 4'd0,
    parameter logic [3:0]  OP_ADD    = 4'd5,
    parameter int unsigned CARRY_BIT = 1,
    parameter bit          FAST_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_op,
    input  logic [7:0]  alu_out,
    input  logic [3:0]  alu_flags
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  mcand_q, mcand_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  q_q, q_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] product_q, product_d;
    logic        carry;
    logic        unused_flags;

    // Only the carry flag matters; the remaining flag bits are deliberately ignored.
    assign unused_flags = ^alu_flags;
    assign carry        = alu_flags[CARRY_BIT];

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Next-state, ALU drive and shift-and-add step.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        alu_op    = OP_PASS;
        alu_a     = '0;
        alu_b     = '0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    mcand_d = in_a;
                    q_d     = in_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    if (FAST_ZERO && (in_a == '0 || in_b == '0)) begin
                        product_d = '0;
                        state_d   = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                alu_a = acc_q;
                if (q_q[0]) begin
                    alu_op = OP_ADD;
                    alu_b  = mcand_q;
                end else begin
                    alu_op = OP_PASS;
                    alu_b  = acc_q;
                end
                // The carry shifts into acc[7], so the 9-bit sum is never truncated.
                acc_d = {carry, alu_out[7:1]};
                q_d   = {alu_out[0], q_q[7:1]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    product_d = {acc_d, q_d};
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign product   = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: randomized and directed checks of alu_mul_seq against a
// transaction-level model, with a behavioural ALU on the alu_* ports.
module tb_alu_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  in_a, in_b, alu_a, alu_b, alu_out;
    logic [15:0] product;
    logic [3:0]  alu_op, alu_flags;

    // Second instance with FAST_ZERO disabled.
    logic        v0, rdy0, ov0, r0, busy0;
    logic [7:0]  a0, b0, alu_a0, alu_b0, alu_out0;
    logic [15:0] prod0;
    logic [3:0]  alu_op0, alu_flags0;

    int n_chk  = 0;
    int n_fail = 0;

    alu_mul_seq #(.OP_PASS(4'd0), .OP_ADD(4'd5), .CARRY_BIT(1), .FAST_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_out(alu_out), .alu_flags(alu_flags)
    );

    alu_mul_seq #(.OP_PASS(4'd0), .OP_ADD(4'd5), .CARRY_BIT(1), .FAST_ZERO(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0),
        .in_a(a0), .in_b(b0), .out_valid(ov0), .out_ready(r0),
        .product(prod0), .busy(busy0), .alu_a(alu_a0), .alu_b(alu_b0),
        .alu_op(alu_op0), .alu_out(alu_out0), .alu_flags(alu_flags0)
    );

    function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = 9'(a) + 9'(b);
        if (op == 4'd5) return {2'b00, s[8], 1'b0, s[7:0]};
        return {4'b0000, b};
    endfunction

    always_comb {alu_flags,  alu_out}  = alu_fn(alu_op,  alu_a,  alu_b);
    always_comb {alu_flags0, alu_out0} = alu_fn(alu_op0, alu_a0, alu_b0);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          m_wait  = 0;      // RUN cycles still to go
    bit          m_valid = 1'b0;   // a product is being offered
    logic [15:0] m_prod;
    logic [7:0]  m_a, m_b;
    int          n_acc  = 0;
    int          n_done = 0;
    logic [15:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wait  <= 0;
            m_valid <= 1'b0;
            m_prod  <= '0;
            exp_q.delete();
        end else if (m_valid) begin
            if (out_ready) m_valid <= 1'b0;
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_valid <= 1'b1;
                m_prod  <= 16'(m_a) * 16'(m_b);
            end
        end else if (in_valid) begin
            m_a <= in_a;
            m_b <= in_b;
            exp_q.push_back(16'(in_a) * 16'(in_b));
            n_acc++;
            if (in_a == 8'd0 || in_b == 8'd0) begin
                m_valid <= 1'b1;
                m_prod  <= '0;
            end else begin
                m_wait <= 8;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        int          k;
        logic [15:0] lowb, part;
        logic [7:0]  e_acc;
        logic        e_add;
        chk("in_ready",  in_ready,  rst_n && !m_valid && m_wait == 0);
        chk("out_valid", out_valid, m_valid);
        chk("busy",      busy,      m_wait > 0);
        chk("product",   product,   m_prod);
        if (m_wait > 0) begin
            k     = 8 - m_wait;
            e_add = m_b[k];
            lowb  = 16'(m_b) & ((16'd1 << k) - 16'd1);
            part  = 16'(m_a) * lowb;
            e_acc = 8'(part >> k);
            chk("alu_op_run", alu_op, e_add ? 4'd5 : 4'd0);
            chk("alu_a_run",  alu_a,  e_acc);
            chk("alu_b_run",  alu_b,  e_add ? m_a : e_acc);
        end else begin
            chk("alu_op_idle", alu_op, 4'd0);
            chk("alu_ab_idle", {alu_a, alu_b}, 16'd0);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_result", 1'b1, 1'b0);
            end else begin
                chk("sb_order", product, exp_q.pop_front());
                n_done++;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic send(input logic [7:0] a, input logic [7:0] b, output int lat, output int nbusy);
        int g;
        in_a = a; in_b = b; in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 100) begin
            @(posedge clk); #1; g++;
        end
        chk("accept_timeout", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; nbusy = 0;
        while (!out_valid && lat < 20) begin
            nbusy += int'(busy);
            @(posedge clk); #1; lat++;
        end
        chk("valid_timeout", out_valid, 1'b1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("handshake_done", out_valid, 1'b0);
    endtask

    initial begin
        int lat, nb, start, g;
        logic [7:0] za [2];
        logic [7:0] zb [2];
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        v0 = 1'b0; a0 = '0; b0 = '0; r0 = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_product",   product,   16'd0);
        chk("rst_alu_op",    alu_op,    4'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", in_ready, 1'b1);

        // 13*11 with out_ready already high.
        out_ready = 1'b1;
        send(8'd13, 8'd11, lat, nb);
        chk("p_13x11", product, 16'd143);
        chk("model_13x11", m_prod, 16'd143);
        chk("lat_13x11", lat, 8);
        chk("busy_13x11", nb, 8);
        take();

        send(8'd255, 8'd255, lat, nb);
        chk("p_255x255", product, 16'd65025);
        chk("model_255x255", m_prod, 16'd65025);
        take();
        send(8'd128, 8'd2, lat, nb);
        chk("p_128x2", product, 16'd256);
        take();

        // Zero operands with the fast path.
        za[0] = 8'd0;   zb[0] = 8'd200;
        za[1] = 8'd200; zb[1] = 8'd0;
        for (int i = 0; i < 2; i++) begin
            send(za[i], zb[i], lat, nb);
            chk("p_zero_fast", product, 16'd0);
            chk("lat_zero_fast", lat, 0);
            chk("busy_zero_fast", nb + int'(busy), 0);
            take();
        end

        // Zero operands without the fast path.
        for (int i = 0; i < 2; i++) begin
            a0 = za[i]; b0 = zb[i]; v0 = 1'b1;
            @(posedge clk); #1;
            v0 = 1'b0;
            lat = 0; nb = 0;
            while (!ov0 && lat < 20) begin
                nb += int'(busy0);
                @(posedge clk); #1; lat++;
            end
            chk("p_zero_slow", prod0, 16'd0);
            chk("lat_zero_slow", lat, 8);
            chk("busy_zero_slow", nb, 8);
            @(posedge clk); #1;
            chk("slow_handshake", ov0, 1'b0);
        end

        // Backpressure in DONE.
        out_ready = 1'b0;
        send(8'd7, 8'd9, lat, nb);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
            @(posedge clk); #1;
            chk("bp_product", product, 16'd63);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_valid", out_valid, 1'b0);
        chk("bp_release_ready", in_ready, 1'b1);
        chk("bp_product_hold", product, 16'd63);

        // Reset during RUN cycle 4.
        in_a = 8'd100; in_b = 8'd100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_product", product, 16'd0);
        chk("midrst_alu_op", alu_op, 4'd0);
        chk("midrst_busy", busy, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'd3, 8'd5, lat, nb);
        chk("p_3x5", product, 16'd15);
        chk("lat_3x5", lat, 8);
        take();

        // Back-to-back random traffic.
        start = n_acc;
        in_valid = 1'b1;
        g = 0;
        while (n_acc - start < 20 && g < 2000) begin
            in_a = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            in_b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1; g++;
        end
        in_valid = 1'b0;
        chk("rand_accepts", n_acc - start, 20);
        out_ready = 1'b1;
        g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 100) begin
            @(posedge clk); #1; g++;
        end
        chk("rand_drained", exp_q.size(), 0);
        chk("accept_vs_done", n_done, n_acc - 1);  // one accept was aborted by reset

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
